uart_rx_configurable: RTL and testbench

Next-generation UART receiver for the SAP-2 computer. It replaces the fixed 8N1 receiver and its single frame-error flag.
- Runtime-selectable data bits (5-8), parity (none/even/odd) and stop bits (1/2).
- Parametrised oversampling and an RX FIFO.
- Sticky frame, parity, overrun and break status flags, each with its own clear strobe.
- Sits inside u_uart, between the uart_rx pin and the CPU I/O port decode.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_configurable.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_configurable.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the SAP-2 UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StWaitIdle
  } uart_rx_state_t;

  localparam int unsigned MIN_DATA_BITS = 5;

  // Clocks per oversample tick, truncated; never below one so the tick still fires.
  function automatic int unsigned baud_divisor(input int unsigned clock,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    int unsigned div;
    div = clock / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head reads as zero while empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(DEPTH));

  // A pop frees a slot first, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_configurable.sv
// Configurable UART receiver: 5-8 data bits, optional parity, 1/2 stop bits,
// oversampled line, RX FIFO and sticky per-error status flags.
module uart_rx_configurable
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 2_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_serial_in,
  input  logic [1:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_two_stop,
  input  logic                  rx_pop,
  input  logic                  cmd_clear_frame_error,
  input  logic                  cmd_clear_parity_error,
  input  logic                  cmd_clear_overrun,
  input  logic                  cmd_clear_break,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_fifo_full,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  overrun_error,
  output logic                  break_detect,
  output logic                  rx_busy
);

  localparam int unsigned DIV    = baud_divisor(CLOCK_SPEED, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  uart_rx_state_t        state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_pend_q, par_pend_d;
  logic [1:0]            data_bits_q, data_bits_d;
  parity_mode_t          parity_q, parity_d;
  logic                  two_stop_q, two_stop_d;
  logic                  push_q, push_d;

  logic tick, start_sample, mid_bit, par_en, exp_par;
  logic [3:0] last_bit;
  logic frame_set, break_set, parity_set, overrun_set;
  logic fifo_empty, fifo_full;

  assign rx_s         = sync_q[1];
  assign tick         = (div_cnt_q == DIV_LAST);
  assign start_sample = tick && (tick_cnt_q == TICK_HALF);
  assign mid_bit      = tick && (tick_cnt_q == TICK_LAST);
  assign par_en       = (parity_q == PAR_EVEN) || (parity_q == PAR_ODD);
  assign exp_par      = (^data_q) ^ (parity_q == PAR_ODD);
  assign last_bit     = 4'(MIN_DATA_BITS - 1) + {2'b00, data_bits_q};

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d  = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    par_pend_d  = par_pend_q;
    data_bits_d = data_bits_q;
    parity_d    = parity_q;
    two_stop_d  = two_stop_q;
    push_d      = 1'b0;
    frame_set   = 1'b0;
    break_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          data_bits_d = cfg_data_bits;
          parity_d    = parity_mode_t'(cfg_parity);
          two_stop_d  = cfg_two_stop;
          div_cnt_d   = '0;
          tick_cnt_d  = '0;
          bit_cnt_d   = '0;
          data_d      = '0;
          par_bit_d   = 1'b0;
          par_pend_d  = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (start_sample) begin
          tick_cnt_d = '0;
          state_d    = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (mid_bit) begin
          tick_cnt_d = '0;
          data_d     = data_q | (DATA_WIDTH'(rx_s) << bit_cnt_q);
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == last_bit) state_d = par_en ? StParity : StStop1;
        end
      end
      StParity: begin
        if (mid_bit) begin
          tick_cnt_d = '0;
          par_bit_d  = rx_s;
          par_pend_d = (rx_s != exp_par);
          state_d    = StStop1;
        end
      end
      StStop1: begin
        if (mid_bit) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            frame_set = 1'b1;
            break_set = (data_q == '0) && (!par_en || !par_bit_q);
            state_d   = StWaitIdle;
          end else if (two_stop_q) begin
            state_d = StStop2;
          end else begin
            push_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StStop2: begin
        if (mid_bit) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            frame_set = 1'b1;
            state_d   = StWaitIdle;
          end else begin
            push_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      par_pend_q  <= 1'b0;
      data_bits_q <= '0;
      parity_q    <= PAR_NONE;
      two_stop_q  <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_serial_in};
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      par_pend_q  <= par_pend_d;
      data_bits_q <= data_bits_d;
      parity_q    <= parity_d;
      two_stop_q  <= two_stop_d;
      push_q      <= push_d;
    end
  end

  // data_q and par_pend_q stay stable through the push cycle even if a new start arrives.
  assign parity_set  = push_q & par_pend_q;
  assign overrun_set = push_q & fifo_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      frame_error   <= frame_set   | (frame_error   & ~cmd_clear_frame_error);
      parity_error  <= parity_set  | (parity_error  & ~cmd_clear_parity_error);
      overrun_error <= overrun_set | (overrun_error & ~cmd_clear_overrun);
      break_detect  <= break_set   | (break_detect  & ~cmd_clear_break);
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (rx_pop),
    .din   (data_q),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rx_valid     = ~fifo_empty;
  assign rx_fifo_full = fifo_full;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_configurable.sv
// Bench for uart_rx_configurable: vector table of frames plus hand-written
// break, glitch, overrun and mid-frame reset sequences, scoreboarded bytes.
module tb_uart_rx_configurable;

  localparam int unsigned CLOCK_SPEED = 2_000_000;
  localparam int unsigned BAUD_RATE   = 9600;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned DIV         = CLOCK_SPEED / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned BIT_CLKS    = DIV * OVERSAMPLE;
  localparam int          NV          = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] cfg_data_bits = 2'd3;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_two_stop = 1'b0;
  logic       rx_pop = 1'b0;
  logic       clr_frame = 1'b0, clr_parity = 1'b0, clr_overrun = 1'b0, clr_break = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_fifo_full, frame_error, parity_error, overrun_error;
  logic       break_detect, rx_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] bits;
    logic [1:0] par;
    logic       two;
    logic       flip;
    logic       bad;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_frame;
    logic       exp_perr;
    logic       exp_brk;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  uart_rx_configurable #(
    .CLOCK_SPEED (CLOCK_SPEED),
    .BAUD_RATE   (BAUD_RATE),
    .OVERSAMPLE  (OVERSAMPLE),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rx_serial_in           (rx),
    .cfg_data_bits          (cfg_data_bits),
    .cfg_parity             (cfg_parity),
    .cfg_two_stop           (cfg_two_stop),
    .rx_pop                 (rx_pop),
    .cmd_clear_frame_error  (clr_frame),
    .cmd_clear_parity_error (clr_parity),
    .cmd_clear_overrun      (clr_overrun),
    .cmd_clear_break        (clr_break),
    .rx_data                (rx_data),
    .rx_valid               (rx_valid),
    .rx_fifo_full           (rx_fifo_full),
    .frame_error            (frame_error),
    .parity_error           (parity_error),
    .overrun_error          (overrun_error),
    .break_detect           (break_detect),
    .rx_busy                (rx_busy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check_head(input string name);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h, expected no data (scoreboard empty)", name, rx_data);
    end else begin
      e = sb_q.pop_front();
      check8(name, rx_data, e);
    end
  endtask

  task automatic check_flags(input string name, input logic f, input logic p, input logic o,
                             input logic b);
    check1({name, " frame_error"}, frame_error, f);
    check1({name, " parity_error"}, parity_error, p);
    check1({name, " overrun_error"}, overrun_error, o);
    check1({name, " break_detect"}, break_detect, b);
  endtask

  task automatic drive_bits(input logic b, input int nbits);
    rx = b;
    repeat (nbits * BIT_CLKS) @(posedge clk);
  endtask

  // Full frame; flip inverts the parity bit, bad forces the final stop bit low.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                            input logic two, input logic flip, input logic bad);
    logic [7:0] mask;
    logic       p;
    mask = 8'((32'd1 << nb) - 32'd1);
    p    = (^(d & mask)) ^ (par == 2'b10);
    drive_bits(1'b0, 1);
    for (int i = 0; i < nb; i++) drive_bits(d[i], 1);
    if (par == 2'b01 || par == 2'b10) drive_bits(p ^ flip, 1);
    if (two) drive_bits(1'b1, 1);
    drive_bits(~bad, 1);
    drive_bits(1'b1, 1);
  endtask

  task automatic pop_one();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic clear_all();
    {clr_frame, clr_parity, clr_overrun, clr_break} = 4'hF;
    @(negedge clk);
    {clr_frame, clr_parity, clr_overrun, clr_break} = 4'h0;
  endtask

  initial begin
    int         occ;
    logic       exp_ovr;
    logic [7:0] partial;

    //          data   bits  par   two   flip  bad   valid exp    frm   perr  brk
    vecs[0]  = '{8'hA5, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h41, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h41, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'hDD, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h3C, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h13, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h96, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hFF, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check1("reset rx_valid", rx_valid, 1'b0);
    check8("reset rx_data", rx_data, 8'h00);
    check1("reset rx_busy", rx_busy, 1'b0);
    check1("reset rx_fifo_full", rx_fifo_full, 1'b0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < NV; v++) begin
      cfg_data_bits = vecs[v].bits;
      cfg_parity    = vecs[v].par;
      cfg_two_stop  = vecs[v].two;
      if (vecs[v].exp_valid) sb_q.push_back(vecs[v].exp_data);
      send_frame(vecs[v].data, 5 + int'(vecs[v].bits), vecs[v].par, vecs[v].two,
                 vecs[v].flip, vecs[v].bad);
      @(negedge clk);
      check1($sformatf("vec%0d rx_valid", v), rx_valid, vecs[v].exp_valid);
      check_flags($sformatf("vec%0d", v), vecs[v].exp_frame, vecs[v].exp_perr, 1'b0,
                  vecs[v].exp_brk);
      if (rx_valid) begin
        sb_check_head($sformatf("vec%0d rx_data", v));
        pop_one();
        check1($sformatf("vec%0d rx_valid after pop", v), rx_valid, 1'b0);
      end
      clear_all();
      check_flags($sformatf("vec%0d cleared", v), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Line held low for 20 bit times.
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    cfg_two_stop  = 1'b0;
    drive_bits(1'b0, 20);
    @(negedge clk);
    check1("break rx_busy low line", rx_busy, 1'b1);
    check1("break rx_valid", rx_valid, 1'b0);
    check_flags("break", 1'b1, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check1("break rx_busy after release", rx_busy, 1'b0);
    clear_all();
    check_flags("break cleared", 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bits(1'b1, 1);

    // Short low glitch is a false start.
    @(negedge clk);
    rx = 1'b0;
    repeat (OVERSAMPLE / 4 * DIV) @(negedge clk);
    check1("glitch rx_busy in start", rx_busy, 1'b1);
    rx = 1'b1;
    drive_bits(1'b1, 2);
    @(negedge clk);
    check1("glitch rx_busy", rx_busy, 1'b0);
    check1("glitch rx_valid", rx_valid, 1'b0);
    check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

    // Overfill: model tracks occupancy and predicts the dropped byte.
    occ     = 0;
    exp_ovr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (occ < int'(FIFO_DEPTH)) begin
        sb_q.push_back(8'(i));
        occ++;
      end else begin
        exp_ovr = 1'b1;
      end
      send_frame(8'(i), 8, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check1("overrun rx_fifo_full", rx_fifo_full, 1'b1);
    check1("overrun flag", overrun_error, exp_ovr);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      check1($sformatf("drain%0d rx_valid", i), rx_valid, 1'b1);
      sb_check_head($sformatf("drain%0d rx_data", i));
      pop_one();
    end
    check1("drained rx_valid", rx_valid, 1'b0);
    check1("drained rx_fifo_full", rx_fifo_full, 1'b0);
    pop_one();
    check1("pop on empty rx_valid", rx_valid, 1'b0);
    clear_all();
    check1("overrun cleared", overrun_error, 1'b0);

    // A byte sits in the FIFO, then reset lands in the middle of 0x7E's data bits.
    sb_q.push_back(8'h11);
    send_frame(8'h11, 8, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check1("pre-reset rx_valid", rx_valid, 1'b1);
    sb_check_head("pre-reset rx_data");
    partial = 8'h7E;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bits(partial[i], 1);
    @(negedge clk);
    check1("mid-frame rx_busy", rx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check1("mid reset rx_valid", rx_valid, 1'b0);
    check8("mid reset rx_data", rx_data, 8'h00);
    check1("mid reset rx_busy", rx_busy, 1'b0);
    check1("mid reset rx_fifo_full", rx_fifo_full, 1'b0);
    check_flags("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive_bits(1'b1, 2);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 8, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check1("post-reset rx_valid", rx_valid, 1'b1);
    sb_check_head("post-reset rx_data");
    check_flags("post-reset", 1'b0, 1'b0, 1'b0, 1'b0);
    pop_one();
    check1("post-reset rx_valid after pop", rx_valid, 1'b0);
    check8("scoreboard drained", 8'(sb_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
